// File: rtl/uart8_tx_buffered_if.sv
// Byte-load / serial-line interface of the buffered 8N1 UART transmitter.
//   txEn    : enable; when low no new frame starts
//   txStart : load strobe, accepted when txStart && txReady
//   in      : byte to transmit
//   txReady : holding register empty
//   out     : serial line, idles high
//   txBusy  : frame on the line
//   txDone  : one-cycle pulse on the last cycle of the final stop bit
interface uart8_tx_buffered_if;
    logic       txEn;
    logic       txStart;
    logic [7:0] in;
    logic       txReady;
    logic       out;
    logic       txBusy;
    logic       txDone;

    modport master (
        output txEn, txStart, in,
        input  txReady, out, txBusy, txDone
    );

    modport slave (
        input  txEn, txStart, in,
        output txReady, out, txBusy, txDone
    );
endinterface

// File: rtl/uart8_tx_buffered.sv
// 8N1 UART transmitter with a one-byte holding register so consecutive
// frames go out with no idle gap.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : uart8_tx_buffered_if.slave (txEn, txStart, in, txReady, out,
//           txBusy, txDone); all outputs registered
module uart8_tx_buffered #(
    parameter int unsigned CLOCK_RATE = 12000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    uart8_tx_buffered_if.slave         bus
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
    localparam int unsigned DIV_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;       // data bit index, reused as stop-bit count
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             bit_end;
    logic             load;
    logic             take;

    // Next-state, holding register and registered-output logic
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        take        = 1'b0;
        load        = bus.txStart && ready_q;
        bit_end     = (div_q == DIV_LAST);

        if (state_q != IDLE) begin
            div_d = bit_end ? '0 : div_q + DIV_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (hold_full_q && bus.txEn) take = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        if (hold_full_q && bus.txEn) take = 1'b1;
                        else                         state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Holding-to-shift transfer; never coincides with a load since it needs holding full
        if (take) begin
            state_d     = START;
            div_d       = '0;
            idx_d       = '0;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
        end

        if (load) begin
            hold_d      = bus.in;
            hold_full_d = 1'b1;
        end

        // Outputs are computed from the next state so they are registered yet cycle-aligned
        case (state_d)
            START:   out_d = 1'b0;
            DATA:    out_d = shift_d[idx_d];
            default: out_d = 1'b1;
        endcase
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == STOP) && (div_d == DIV_LAST) && (idx_d == STOP_LAST);
        ready_d = ~hold_full_d;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            div_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            out_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            out_q       <= out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.txBusy  = busy_q;
    assign bus.txDone  = done_q;
    assign bus.txReady = ready_q;

endmodule

// File: tb/tb_uart8_tx_buffered.sv
// Self-checking bench for uart8_tx_buffered: three instances (default rate,
// 16 clks/bit, 16 clks/bit with two stop bits), a line-decoding scoreboard
// and a table of byte/line-level vectors.
module tb_uart8_tx_buffered;

    typedef struct {
        logic [7:0] din;
        logic [0:9] line;   // expected levels start..stop, in line order
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_en;
    logic       tx_start;
    logic [7:0] tx_in;
    int         sel;
    int         cyc = 0;

    int tests = 0;
    int fails = 0;

    logic [7:0] sb[$];
    int         done_cyc[$];

    logic mon_out, mon_busy, mon_done, mon_ready;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart8_tx_buffered_if if_def ();
    uart8_tx_buffered_if if_fast ();
    uart8_tx_buffered_if if_s2 ();

    assign if_def.txEn     = tx_en;
    assign if_def.txStart  = tx_start && (sel == 0);
    assign if_def.in       = tx_in;
    assign if_fast.txEn    = tx_en;
    assign if_fast.txStart = tx_start && (sel == 1);
    assign if_fast.in      = tx_in;
    assign if_s2.txEn      = tx_en;
    assign if_s2.txStart   = tx_start && (sel == 2);
    assign if_s2.in        = tx_in;

    uart8_tx_buffered u_def (
        .clk   (clk),
        .reset (reset),
        .bus   (if_def.slave)
    );

    uart8_tx_buffered #(.CLOCK_RATE(160000), .BAUD_RATE(10000)) u_fast (
        .clk   (clk),
        .reset (reset),
        .bus   (if_fast.slave)
    );

    uart8_tx_buffered #(.CLOCK_RATE(160000), .BAUD_RATE(10000), .STOP_BITS(2)) u_s2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if_s2.slave)
    );

    always_comb begin
        case (sel)
            0: begin
                mon_out = if_def.out; mon_busy = if_def.txBusy;
                mon_done = if_def.txDone; mon_ready = if_def.txReady;
            end
            1: begin
                mon_out = if_fast.out; mon_busy = if_fast.txBusy;
                mon_done = if_fast.txDone; mon_ready = if_fast.txReady;
            end
            default: begin
                mon_out = if_s2.out; mon_busy = if_s2.txBusy;
                mon_done = if_s2.txDone; mon_ready = if_s2.txReady;
            end
        endcase
    end

    function automatic int cpb_of(input int s);
        return (s == 0) ? 1250 : 16;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a byte and record it as expected on the line
    task automatic arm(input logic [7:0] d);
        tx_in    = d;
        tx_start = 1'b1;
        sb.push_back(d);
    endtask

    task automatic load(input logic [7:0] d);
        arm(d);
        tick();
        tx_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(mon_busy === 1'b0 && mon_ready === 1'b1) && n < 30000) begin
            tick();
            n++;
        end
        chk({name, "_idle_wait"}, 32'(n < 30000), 32'd1);
    endtask

    // Called on the first cycle of a start bit; walks the whole frame cycle by cycle
    task automatic check_frame(input logic [0:10] exp, input int nbits, input int cpb,
                               input bit idle_after, input string name);
        int bad_busy = 0;
        int done_n   = 0;
        int done_at  = -1;
        for (int k = 0; k < nbits; k++) begin
            int bad = 0;
            for (int c = 0; c < cpb; c++) begin
                if (mon_out !== exp[k]) bad++;
                if (mon_busy !== 1'b1) bad_busy++;
                if (mon_done === 1'b1) begin
                    done_n++;
                    done_at = k * cpb + c + 1;
                end
                tick();
                tx_start = 1'b0;
            end
            chk($sformatf("%s_bit%0d_level", name, k), 32'(bad), 32'd0);
        end
        chk({name, "_busy_cycles"}, 32'(bad_busy), 32'd0);
        chk({name, "_done_count"}, 32'(done_n), 32'd1);
        chk({name, "_done_cycle"}, 32'(done_at), 32'(nbits * cpb));
        chk({name, "_done_after"}, 32'(mon_done), 32'd0);
        if (idle_after) begin
            chk({name, "_out_after"}, 32'(mon_out), 32'd1);
            chk({name, "_busy_after"}, 32'(mon_busy), 32'd0);
        end else begin
            chk({name, "_next_start"}, 32'(mon_out), 32'd0);
            chk({name, "_next_busy"}, 32'(mon_busy), 32'd1);
        end
    endtask

    // Scoreboard: decode frames from the selected line at mid-bit and match queued bytes
    bit         m_act = 1'b0;
    int         m_cnt;
    int         m_c;
    int         m_k;
    logic [7:0] m_byte;
    logic [7:0] m_exp;

    always @(negedge clk) begin
        if (reset) begin
            m_act = 1'b0;
            sb.delete();
        end else if (!m_act) begin
            if (mon_out === 1'b0) begin
                m_act = 1'b1;
                m_cnt = 0;
            end
        end else begin
            m_cnt++;
            m_c = cpb_of(sel);
            if (m_cnt % m_c == m_c / 2) begin
                m_k = m_cnt / m_c;
                if (m_k >= 1 && m_k <= 8) begin
                    m_byte[m_k-1] = mon_out;
                end else if (m_k == 9) begin
                    chk("sb_frame_expected", 32'(sb.size() > 0), 32'd1);
                    if (sb.size() > 0) begin
                        m_exp = sb.pop_front();
                        chk("sb_byte", 32'(m_byte), 32'(m_exp));
                    end
                    chk("sb_stop_bit", 32'(mon_out), 32'd1);
                    m_act = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_done === 1'b1) done_cyc.push_back(cyc);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        vec_t vecs[4];
        int   n0;

        vecs[0] = '{8'h00, 10'b0000000001};
        vecs[1] = '{8'hFF, 10'b0111111111};
        vecs[2] = '{8'hC3, 10'b0110000111};
        vecs[3] = '{8'h81, 10'b0100000011};

        reset    = 1'b1;
        tx_en    = 1'b1;
        tx_start = 1'b0;
        tx_in    = 8'h00;
        sel      = 1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();

        // Reset held two cycles while idle
        reset = 1'b1;
        repeat (2) tick();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk($sformatf("reset%0d_out", s), 32'(mon_out), 32'd1);
            chk($sformatf("reset%0d_ready", s), 32'(mon_ready), 32'd1);
            chk($sformatf("reset%0d_busy", s), 32'(mon_busy), 32'd0);
            chk($sformatf("reset%0d_done", s), 32'(mon_done), 32'd0);
        end
        reset = 1'b0;
        tick();

        // Single byte at the default rate
        sel = 0;
        #1;
        load(8'h35);
        chk("def_ready_after_load", 32'(mon_ready), 32'd0);
        chk("def_out_before_start", 32'(mon_out), 32'd1);
        tick();
        chk("def_ready_at_start", 32'(mon_ready), 32'd1);
        check_frame({10'b0101011001, 1'b1}, 10, 1250, 1'b1, "def");

        // Table of single frames at 16 clks/bit
        sel = 1;
        #1;
        for (int i = 0; i < 4; i++) begin
            wait_idle($sformatf("vec%0d", i));
            load(vecs[i].din);
            tick();
            check_frame({vecs[i].line, 1'b1}, 10, 16, 1'b1, $sformatf("vec%0d", i));
        end

        // Back-to-back frames: second byte loaded on the first start-bit cycle
        wait_idle("b2b");
        n0 = done_cyc.size();
        load(8'h35);
        tick();
        chk("b2b_ready_at_start", 32'(mon_ready), 32'd1);
        arm(8'hA5);
        check_frame({10'b0101011001, 1'b1}, 10, 16, 1'b0, "b2b1");
        chk("b2b_ready_after_transfer", 32'(mon_ready), 32'd1);
        check_frame({10'b0101001011, 1'b1}, 10, 16, 1'b1, "b2b2");
        chk("b2b_done_pulses", 32'(done_cyc.size() - n0), 32'd2);
        if (done_cyc.size() - n0 == 2)
            chk("b2b_done_spacing", 32'(done_cyc[n0+1] - done_cyc[n0]), 32'd160);

        // txEn gating: held byte waits, extra loads ignored
        wait_idle("gate");
        tx_en = 1'b0;
        load(8'h5A);
        repeat (20) tick();
        chk("gate_out_idle", 32'(mon_out), 32'd1);
        chk("gate_ready_low", 32'(mon_ready), 32'd0);
        chk("gate_busy_low", 32'(mon_busy), 32'd0);
        tx_in    = 8'h00;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        repeat (5) tick();
        chk("gate_ignored_ready", 32'(mon_ready), 32'd0);
        chk("gate_ignored_out", 32'(mon_out), 32'd1);
        tx_en = 1'b1;
        tick();
        check_frame({10'b0010110101, 1'b1}, 10, 16, 1'b1, "gate");

        // Reset during data bit 4, then a clean frame
        wait_idle("rstmid");
        n0 = done_cyc.size();
        load(8'h81);
        tick();
        repeat (5 * 16 + 3) tick();
        chk("rstmid_in_bit4", 32'(mon_out), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmid_out", 32'(mon_out), 32'd1);
        chk("rstmid_busy", 32'(mon_busy), 32'd0);
        chk("rstmid_ready", 32'(mon_ready), 32'd1);
        chk("rstmid_done", 32'(mon_done), 32'd0);
        repeat (200) tick();
        chk("rstmid_no_done", 32'(done_cyc.size() - n0), 32'd0);
        chk("rstmid_line_high", 32'(mon_out), 32'd1);
        load(8'hFF);
        tick();
        check_frame({10'b0111111111, 1'b1}, 10, 16, 1'b1, "rstmid_ff");

        // Two stop bits
        sel = 2;
        #1;
        wait_idle("s2");
        load(8'h00);
        tick();
        check_frame(11'b00000000011, 11, 16, 1'b1, "s2");

        repeat (20) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
